// File: rtl/ringosc_ctrl.sv
// Ring-oscillator frequency measurement controller: enables the oscillator, lets it settle,
// counts synchronized rising edges over a selectable window and holds the result until acknowledged.
module ringosc_ctrl #(
   parameter int SETTLE_CYC = 8,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [2:0]       window_sel,
   input  logic             osc_in,
   output logic             osc_enable,
   output logic             busy,
   output logic [CNT_W-1:0] count,
   output logic             count_valid,
   output logic             overflow,
   input  logic             result_ack,
   output logic [1:0]       state_dbg
);

   // Handshake: a result is offered while count_valid=1 and is consumed on the first
   // clock edge that sees result_ack=1; count and overflow stay frozen until then.

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      MEASURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam logic [7:0]       SETTLE_INIT = 8'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   state_t      state;
   state_t      state_nxt;
   logic        s1;
   logic        s2;
   logic        s3;
   logic        osc_rise;
   logic [7:0]  settle_cnt;
   logic [11:0] win_cnt;
   logic [11:0] win_len;
   logic [2:0]  win_sel_q;

   assign osc_rise = s2 & ~s3;
   assign win_len  = 12'd16 << win_sel_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start && !abort) state_nxt = SETTLE;
         end
         SETTLE: begin
            if (abort)                  state_nxt = IDLE;
            else if (settle_cnt == 8'd0) state_nxt = MEASURE;
         end
         MEASURE: begin
            if (abort)                  state_nxt = IDLE;
            else if (win_cnt == 12'd1)  state_nxt = DONE;
         end
         DONE: begin
            if (result_ack) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign osc_enable  = (state == SETTLE) || (state == MEASURE);
   assign busy        = (state != IDLE);
   assign count_valid = (state == DONE);
   assign state_dbg   = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1         <= 1'b0;
         s2         <= 1'b0;
         s3         <= 1'b0;
         settle_cnt <= 8'd0;
         win_cnt    <= 12'd0;
         win_sel_q  <= 3'd0;
         count      <= '0;
         overflow   <= 1'b0;
      end else begin
         s1 <= osc_in;
         s2 <= s1;
         s3 <= s2;
         if (state == IDLE && state_nxt == SETTLE) begin
            win_sel_q  <= window_sel;
            settle_cnt <= SETTLE_INIT;
         end else if (state == SETTLE && settle_cnt != 8'd0) begin
            settle_cnt <= settle_cnt - 8'd1;
         end
         // Edges seen outside MEASURE are the synchronizer tail and are simply dropped.
         if (state == SETTLE && state_nxt == MEASURE) begin
            count    <= '0;
            overflow <= 1'b0;
            win_cnt  <= win_len;
         end else if (state == MEASURE) begin
            win_cnt <= win_cnt - 12'd1;
            if (osc_rise) begin
               if (count == CNT_MAX) overflow <= 1'b1;
               else                  count    <= count + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ringosc_ctrl.sv
// Self-checking bench for ringosc_ctrl: directed scenarios plus randomized windows and
// oscillator patterns, checked against an edge-counting model over recorded osc_in samples.
module tb_ringosc_ctrl;

   localparam int S    = 8;
   localparam int CW   = 8;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          abort;
   logic [2:0]    window_sel;
   logic          osc_in = 1'b0;
   logic          osc_enable;
   logic          busy;
   logic [CW-1:0] count;
   logic          count_valid;
   logic          overflow;
   logic          result_ack;
   logic [1:0]    state_dbg;

   int tests_run    = 0;
   int tests_failed = 0;

   int   cyc = 0;
   logic hist [0:65535];
   int   osc_mode = 0;
   int   osc_half = 1;
   int   osc_cnt  = 0;

   logic [CW-1:0] exp_q [$];

   ringosc_ctrl #(.SETTLE_CYC(S), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .window_sel(window_sel),
      .osc_in(osc_in), .osc_enable(osc_enable), .busy(busy), .count(count),
      .count_valid(count_valid), .overflow(overflow), .result_ack(result_ack),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   // Record the value of osc_in seen at every rising edge.
   always @(posedge clk) begin
      if (cyc < 65536) hist[cyc] = osc_in;
      cyc = cyc + 1;
   end

   always @(negedge clk) begin
      case (osc_mode)
         1: begin
            if (osc_cnt >= osc_half - 1) begin
               osc_in  = ~osc_in;
               osc_cnt = 0;
            end else begin
               osc_cnt = osc_cnt + 1;
            end
         end
         2:       osc_in = 1'($urandom_range(0, 1));
         default: osc_in = 1'b0;
      endcase
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests_run, tests_failed);
      $fatal(1, "watchdog");
   end

   // A rising edge sampled at posedge k reaches the edge detector two edges later; count
   // the ones that land on the L edges whose preceding cycle is inside the window.
   function automatic int model_edges(int n0, int len);
      int sum = 0;
      for (int m = n0 + S + 1; m <= n0 + S + len; m++)
         if (hist[m-2] === 1'b1 && hist[m-3] === 1'b0) sum++;
      return sum;
   endfunction

   task automatic start_meas(input logic [2:0] sel, output int n0);
      @(negedge clk);
      window_sel = sel;
      start      = 1'b1;
      @(posedge clk);
      #1;
      n0         = cyc - 1;
      start      = 1'b0;
      window_sel = 3'($urandom_range(0, 7));
   endtask

   task automatic wait_done(output int lat, output bit en_ok);
      en_ok = 1'b1;
      lat   = 0;
      while (count_valid !== 1'b1 && lat < 4200) begin
         if (osc_enable !== 1'b1 || busy !== 1'b1) en_ok = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic do_ack(input logic st);
      @(negedge clk);
      start      = st;
      abort      = 1'b0;
      result_ack = 1'b1;
      @(posedge clk);
      #1;
      result_ack = 1'b0;
      start      = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if ({osc_enable, busy, count_valid, overflow, count} !== '0) begin
         tests_failed++;
         $display("FAIL reset_hold: en=%b busy=%b valid=%b ovf=%b count=%0d expected all 0",
                  osc_enable, busy, count_valid, overflow, count);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if ({osc_enable, busy, count_valid, overflow, count} !== '0) begin
         tests_failed++;
         $display("FAIL reset_release: en=%b busy=%b valid=%b ovf=%b count=%0d expected all 0",
                  osc_enable, busy, count_valid, overflow, count);
      end
   endtask

   task automatic test_nominal();
      int n0, lat, exp_n;
      bit en_ok;
      osc_mode = 1;
      osc_half = 2;
      repeat (4) @(posedge clk);
      #1;
      tests_run++;
      if (osc_enable !== 1'b0) begin
         tests_failed++;
         $display("FAIL nominal_en_idle: osc_enable=%b expected 0", osc_enable);
      end
      start_meas(3'd0, n0);
      wait_done(lat, en_ok);
      exp_n = model_edges(n0, 16);
      tests_run++;
      if (lat !== S + 16 || !en_ok) begin
         tests_failed++;
         $display("FAIL nominal_latency: lat=%0d en_ok=%0d expected %0d and 1", lat, en_ok, S + 16);
      end
      tests_run++;
      if (count !== CW'(exp_n) || overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL nominal_count: count=%0d ovf=%b expected %0d and 0", count, overflow, exp_n);
      end
      tests_run++;
      if (count < 3 || count > 5) begin
         tests_failed++;
         $display("FAIL nominal_range: count=%0d expected 4 +/- 1", count);
      end
      do_ack(1'b0);
      tests_run++;
      if (count_valid !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL nominal_ack: valid=%b busy=%b expected 0 and 0", count_valid, busy);
      end
   endtask

   task automatic test_saturation();
      int n0, lat, exp_n;
      bit en_ok;
      osc_mode = 1;
      osc_half = 1;
      start_meas(3'd7, n0);
      wait_done(lat, en_ok);
      exp_n = model_edges(n0, 2048);
      tests_run++;
      if (lat !== S + 2048 || !en_ok) begin
         tests_failed++;
         $display("FAIL sat_latency: lat=%0d en_ok=%0d expected %0d and 1", lat, en_ok, S + 2048);
      end
      tests_run++;
      if (count !== CW'(MAXC) || overflow !== 1'b1 || exp_n <= MAXC) begin
         tests_failed++;
         $display("FAIL sat_count: count=%0d ovf=%b model_edges=%0d expected %0d and 1",
                  count, overflow, exp_n, MAXC);
      end
      do_ack(1'b0);
   endtask

   task automatic test_handshake();
      int n0, lat, exp_n;
      bit en_ok, stable;
      logic [CW-1:0] held;
      osc_mode = 2;
      start_meas(3'd1, n0);
      wait_done(lat, en_ok);
      exp_q.push_back(CW'((model_edges(n0, 32) > MAXC) ? MAXC : model_edges(n0, 32)));
      held   = count;
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         start      = 1'($urandom_range(0, 1));
         abort      = 1'($urandom_range(0, 1));
         result_ack = 1'b0;
         @(posedge clk);
         #1;
         if (count !== held || count_valid !== 1'b1 || busy !== 1'b1) stable = 1'b0;
      end
      tests_run++;
      if (!stable) begin
         tests_failed++;
         $display("FAIL hs_hold: count=%0d valid=%b expected %0d and 1", count, count_valid, held);
      end
      exp_n = exp_q.pop_front();
      tests_run++;
      if (held !== CW'(exp_n)) begin
         tests_failed++;
         $display("FAIL hs_count: count=%0d expected %0d", held, exp_n);
      end
      do_ack(1'b1);
      tests_run++;
      if (count_valid !== 1'b0 || busy !== 1'b0 || osc_enable !== 1'b0) begin
         tests_failed++;
         $display("FAIL hs_ack_idle: valid=%b busy=%b en=%b expected 0 0 0", count_valid, busy, osc_enable);
      end
      start_meas(3'd0, n0);
      wait_done(lat, en_ok);
      exp_n = model_edges(n0, 16);
      tests_run++;
      if (lat !== S + 16 || count !== CW'(exp_n)) begin
         tests_failed++;
         $display("FAIL hs_restart: lat=%0d count=%0d expected %0d and %0d", lat, count, S + 16, exp_n);
      end
      do_ack(1'b0);
   endtask

   task automatic test_abort();
      int n0, lat, exp_n;
      bit en_ok, never_valid;
      osc_mode = 1;
      osc_half = 3;
      start_meas(3'd0, n0);
      repeat (S + 5) @(posedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      tests_run++;
      if (osc_enable !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_measure: en=%b busy=%b expected 0 and 0", osc_enable, busy);
      end
      never_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (count_valid !== 1'b0 || busy !== 1'b0) never_valid = 1'b0;
      end
      tests_run++;
      if (!never_valid) begin
         tests_failed++;
         $display("FAIL abort_no_valid: valid=%b busy=%b expected 0 and 0", count_valid, busy);
      end
      start_meas(3'd2, n0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      tests_run++;
      if (osc_enable !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_settle: en=%b busy=%b expected 0 and 0", osc_enable, busy);
      end
      start_meas(3'd1, n0);
      wait_done(lat, en_ok);
      exp_n = model_edges(n0, 32);
      tests_run++;
      if (lat !== S + 32 || !en_ok || count !== CW'(exp_n) || overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_recover: lat=%0d count=%0d ovf=%b expected %0d %0d 0",
                  lat, count, overflow, S + 32, exp_n);
      end
      do_ack(1'b0);
   endtask

   task automatic test_reset_mid();
      int n0, lat;
      bit en_ok, quiet;
      osc_mode = 1;
      osc_half = 1;
      start_meas(3'd2, n0);
      repeat (S + 10) @(posedge clk);
      @(negedge clk);
      rst   = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      rst   = 1'b0;
      abort = 1'b0;
      tests_run++;
      if ({osc_enable, busy, count_valid, overflow, count} !== '0) begin
         tests_failed++;
         $display("FAIL rst_measure: en=%b busy=%b valid=%b ovf=%b count=%0d expected all 0",
                  osc_enable, busy, count_valid, overflow, count);
      end
      start_meas(3'd0, n0);
      wait_done(lat, en_ok);
      @(negedge clk);
      rst        = 1'b1;
      start      = 1'b1;
      result_ack = 1'b1;
      @(posedge clk);
      #1;
      rst        = 1'b0;
      start      = 1'b0;
      result_ack = 1'b0;
      tests_run++;
      if ({osc_enable, busy, count_valid, overflow, count} !== '0) begin
         tests_failed++;
         $display("FAIL rst_done: en=%b busy=%b valid=%b ovf=%b count=%0d expected all 0",
                  osc_enable, busy, count_valid, overflow, count);
      end
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      quiet = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (busy !== 1'b0 || osc_enable !== 1'b0 || count_valid !== 1'b0) quiet = 1'b0;
         @(posedge clk);
         #1;
      end
      tests_run++;
      if (!quiet) begin
         tests_failed++;
         $display("FAIL start_abort_idle: busy=%b en=%b valid=%b expected 0 0 0", busy, osc_enable, count_valid);
      end
   endtask

   task automatic test_random();
      int n0, lat, len, sum, exp_n;
      bit en_ok, exp_ovf, hold_ok;
      logic [2:0] sel;
      for (int it = 0; it < 10; it++) begin
         sel      = 3'($urandom_range(0, 4));
         len      = 16 << sel;
         osc_mode = $urandom_range(1, 2);
         osc_half = $urandom_range(1, 4);
         start_meas(sel, n0);
         wait_done(lat, en_ok);
         sum     = model_edges(n0, len);
         exp_ovf = (sum > MAXC);
         exp_q.push_back(CW'(exp_ovf ? MAXC : sum));
         tests_run++;
         if (lat !== S + len || !en_ok) begin
            tests_failed++;
            $display("FAIL rand_latency[%0d]: lat=%0d en_ok=%0d expected %0d and 1", it, lat, en_ok, S + len);
         end
         exp_n = exp_q.pop_front();
         tests_run++;
         if (count !== CW'(exp_n) || overflow !== exp_ovf) begin
            tests_failed++;
            $display("FAIL rand_count[%0d]: count=%0d ovf=%b expected %0d and %b",
                     it, count, overflow, exp_n, exp_ovf);
         end
         hold_ok = 1'b1;
         repeat ($urandom_range(0, 4)) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            if (count !== CW'(exp_n) || count_valid !== 1'b1) hold_ok = 1'b0;
         end
         do_ack(1'($urandom_range(0, 1)));
         tests_run++;
         if (!hold_ok || busy !== 1'b0 || count_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rand_ack[%0d]: hold_ok=%0d busy=%b valid=%b expected 1 0 0",
                     it, hold_ok, busy, count_valid);
         end
      end
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      abort      = 1'b0;
      result_ack = 1'b0;
      window_sel = 3'd0;
      test_reset();
      test_nominal();
      test_saturation();
      test_handshake();
      test_abort();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
